lab3_cache_test_mem_responder: RTL and testbench

- Backing-memory responder for the cache's memory-side port. It accepts mem_req_4B_t requests from the cache (cache_req_*) and returns mem_resp_4B_t responses (cache_resp_*) after a fixed, programmable latency.
- It is the responder end of the cache-to-memory val/rdy protocol and is used in cache unit tests and in the cache-plus-memory composition.
- Holds one outstanding request at a time.

---
 rtl/lab3_cache_test_mem_responder.sv | 101 ++++++++++
 tb/tb_lab3_cache_test_mem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lab3_cache_test_mem_responder.sv
// Memory-side responder for cache tests: accepts one request at a time and
// returns the response after a fixed latency.
module lab3_cache_test_mem_responder #(
    parameter int unsigned p_addr_bits = 8,
    parameter int unsigned p_latency   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg
);

    localparam int unsigned Words = 1 << p_addr_bits;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [46:0]       resp_q, resp_d;
    logic [31:0]       mem [Words];

    logic [2:0]             req_type;
    logic [7:0]             req_opaque;
    logic [1:0]             req_len;
    logic [31:0]            req_data;
    logic [p_addr_bits-1:0] req_idx;
    logic                   accept;
    logic                   is_write;
    logic                   unused_addr;

    assign req_type   = memreq_msg[76:74];
    assign req_opaque = memreq_msg[73:66];
    assign req_len    = memreq_msg[33:32];
    assign req_data   = memreq_msg[31:0];
    // Word index from addr[p_addr_bits+1:2]; the rest of addr aliases.
    assign req_idx    = memreq_msg[p_addr_bits+35:36];
    assign unused_addr = ^memreq_msg[65:34];

    assign accept   = (state_q == StIdle) && memreq_val;
    assign is_write = (req_type == 3'd1) || (req_type == 3'd2);

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            mem[req_idx] <= req_data;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        resp_d  = resp_q;
        case (state_q)
            StIdle: begin
                if (memreq_val) begin
                    resp_d = {req_type, req_opaque, 2'b00, req_len,
                              (req_type == 3'd0) ? mem[req_idx] : 32'h0};
                    if (p_latency == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        count_d = 8'(p_latency);
                    end
                end
            end
            StWait: begin
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (memresp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= 8'd0;
            resp_q  <= 47'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            resp_q  <= resp_d;
        end
    end

    assign memreq_rdy  = (state_q == StIdle);
    assign memresp_val = (state_q == StResp);
    assign memresp_msg = resp_q;

endmodule

// File: tb/tb_lab3_cache_test_mem_responder.sv
// Bench for lab3_cache_test_mem_responder: directed and random transactions on
// a latency-2 and a latency-0 instance, checked against an array model.
module tb_lab3_cache_test_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val  [2];
    logic [76:0] req_msg  [2];
    logic        req_rdy  [2];
    logic        resp_val [2];
    logic        resp_rdy [2];
    logic [46:0] resp_msg [2];

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [2][256];
    time         last_acc [2];

    always #5 clk = ~clk;

    lab3_cache_test_mem_responder #(.p_addr_bits(8), .p_latency(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (req_val[0]),
        .memreq_rdy  (req_rdy[0]),
        .memreq_msg  (req_msg[0]),
        .memresp_val (resp_val[0]),
        .memresp_rdy (resp_rdy[0]),
        .memresp_msg (resp_msg[0])
    );

    lab3_cache_test_mem_responder #(.p_addr_bits(8), .p_latency(0)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (req_val[1]),
        .memreq_rdy  (req_rdy[1]),
        .memreq_msg  (req_msg[1]),
        .memresp_val (resp_val[1]),
        .memresp_rdy (resp_rdy[1]),
        .memresp_msg (resp_msg[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request/response transaction; called at a falling edge.
    task automatic txn(input int d, input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] addr, input logic [31:0] data, input int stall);
        int          idx;
        int          n;
        logic [1:0]  len;
        logic [31:0] exp_data;
        logic [46:0] exp_msg;
        logic [46:0] held;
        len      = 2'($urandom);
        idx      = int'((addr >> 2) % 256);
        exp_data = (t == 3'd0) ? model[d][idx] : 32'h0;
        if (t == 3'd1 || t == 3'd2) model[d][idx] = data;
        exp_msg  = {t, op, 2'b00, len, exp_data};

        resp_rdy[d] = (stall == 0);
        req_val[d]  = 1'b1;
        req_msg[d]  = {t, op, addr, len, data};
        check("req_rdy_idle", 64'(req_rdy[d]), 64'd1);
        @(posedge clk);
        last_acc[d] = $time;
        #1;
        req_val[d] = 1'b0;
        req_msg[d] = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("req_rdy_busy", 64'(req_rdy[d]), 64'd0);
        end while (!resp_val[d] && n < 300);
        check("resp_latency", 64'(n), 64'(lat(d) + 1));
        check("resp_msg", 64'(resp_msg[d]), 64'(exp_msg));
        held = resp_msg[d];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_val", 64'(resp_val[d]), 64'd1);
            check("stall_msg", 64'(resp_msg[d]), 64'(held));
            check("stall_req_rdy", 64'(req_rdy[d]), 64'd0);
        end
        resp_rdy[d] = 1'b1;
        @(negedge clk);
        check("resp_val_done", 64'(resp_val[d]), 64'd0);
        check("req_rdy_done", 64'(req_rdy[d]), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        logic [31:0] a;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_val[d]  = 1'b0;
            req_msg[d]  = '0;
            resp_rdy[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_rdy", 64'(req_rdy[d]), 64'd1);
            check("rst_resp_val", 64'(resp_val[d]), 64'd0);
            check("rst_resp_msg", 64'(resp_msg[d]), 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Basic write then read
        txn(0, 3'd1, 8'h05, 32'h100, 32'hdeadbeef, 0);
        txn(0, 3'd0, 8'h06, 32'h100, 32'h0, 0);

        // Backpressure
        txn(0, 3'd0, 8'h07, 32'h100, 32'h0, 5);

        // Aliasing via init
        txn(0, 3'd2, 8'h08, 32'h0000_0400, 32'h11223344, 0);
        txn(0, 3'd0, 8'h09, 32'h0000_0000, 32'h0, 0);

        // Zero latency, back-to-back
        txn(1, 3'd1, 8'h01, 32'h0, 32'h01010101, 0);
        txn(1, 3'd1, 8'h02, 32'h4, 32'h02020202, 0);
        txn(1, 3'd0, 8'h03, 32'h0, 32'h0, 0);
        t0 = last_acc[1];
        txn(1, 3'd0, 8'h04, 32'h4, 32'h0, 0);
        check("b2b_accept_gap", 64'(last_acc[1] - t0), 64'd20);

        // Reset during WAIT
        txn(0, 3'd1, 8'h10, 32'h8, 32'hcafef00d, 0);
        req_val[0] = 1'b1;
        req_msg[0] = {3'd0, 8'h11, 32'h8, 2'b00, 32'h0};
        @(posedge clk);
        #1;
        req_val[0] = 1'b0;
        @(negedge clk);
        check("wait_req_rdy", 64'(req_rdy[0]), 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_resp_val", 64'(resp_val[0]), 64'd0);
        check("midrst_req_rdy", 64'(req_rdy[0]), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst_req_rdy", 64'(req_rdy[0]), 64'd1);
        check("postrst_resp_val", 64'(resp_val[0]), 64'd0);
        txn(0, 3'd0, 8'h12, 32'h8, 32'h0, 0);

        // Unknown type leaves array untouched
        txn(0, 3'd1, 8'h20, 32'h40, 32'h5a5a5a5a, 0);
        txn(0, 3'd3, 8'h21, 32'h40, 32'hffffffff, 0);
        txn(0, 3'd0, 8'h22, 32'h40, 32'h0, 0);

        // Random traffic over indices 0..15 with random aliasing bits
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                txn(d, 3'd1, 8'($urandom), 32'(i) << 2, $urandom, 0);
            end
            for (int i = 0; i < 40; i++) begin
                a = ($urandom & 32'hffff_fc03) | (32'($urandom_range(0, 15)) << 2);
                txn(d, 3'($urandom_range(0, 7)), 8'($urandom), a, $urandom,
                    int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
